data_mem_unit: RTL and testbench

//  Responder for the core's data-memory port: rd_en/wr_en/addr/byte_en/wr_data in, rd_data/mem_busy out.

---
 rtl/data_mem_unit_pkg.sv | 26 ++
 rtl/data_mem_unit_if.sv | 26 ++
 rtl/data_mem_unit_load_store_aligner.sv | 74 +++++++
 rtl/data_mem_unit.sv | 185 ++++++++++++++++++
 tb/tb_data_mem_unit.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_unit_pkg.sv
// Shared types and constants for the data-memory responder.
package data_mem_unit_pkg;

  // Access sequencer states
  typedef enum logic [1:0] {
    Idle  = 2'd0,
    Wait  = 2'd1,
    Done  = 2'd2,
    Fault = 2'd3
  } mem_state_t;

  // Legal low-aligned lane masks (byte, half, word, dword)
  localparam logic [7:0] BeByte  = 8'h01;
  localparam logic [7:0] BeHalf  = 8'h03;
  localparam logic [7:0] BeWord  = 8'h0F;
  localparam logic [7:0] BeDword = 8'hFF;

  // Width of the wait-cycle counter
  localparam int CntW = 8;

  // Number of address bits that select a byte lane within a bus word
  function automatic int lane_bits(input int data_size);
    return $clog2(data_size / 8);
  endfunction

endpackage

// File: rtl/data_mem_unit_if.sv
// Wishbone-classic bus bundle between the responder and RAM/peripherals.
interface data_mem_unit_if #(
  parameter int DATA_SIZE = 32
);
  localparam int NB = DATA_SIZE / 8;

  logic                 wb_cyc;
  logic                 wb_stb;
  logic                 wb_we;
  logic [DATA_SIZE-1:0] wb_adr;
  logic [NB-1:0]        wb_sel;
  logic [DATA_SIZE-1:0] wb_dat_o;
  logic [DATA_SIZE-1:0] wb_dat_i;
  logic                 wb_ack;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_o,
    input  wb_dat_i, wb_ack
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_o,
    output wb_dat_i, wb_ack
  );

endinterface

// File: rtl/data_mem_unit_load_store_aligner.sv
// Combinational byte-lane steering: store shift and lane select, load
// shift/mask/extend, and legality/alignment check of a request.
module data_mem_unit_load_store_aligner
  import data_mem_unit_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  localparam int NB = DATA_SIZE / 8,
  localparam int LB = $clog2(NB)
) (
  input  logic [LB-1:0]        st_off,
  input  logic [NB-1:0]        st_be,
  input  logic [DATA_SIZE-1:0] st_data,
  output logic [NB-1:0]        st_sel,
  output logic [DATA_SIZE-1:0] st_dat,
  output logic                 st_bad,
  input  logic [LB-1:0]        ld_off,
  input  logic [NB-1:0]        ld_be,
  input  logic                 ld_signed,
  input  logic [DATA_SIZE-1:0] ld_raw,
  output logic [DATA_SIZE-1:0] ld_data
);

  logic [LB-1:0]        amask;
  logic                 legal;
  logic [DATA_SIZE-1:0] shifted;
  logic                 sign_bit;
  logic                 fill;

  // Store side: move low-aligned data and lane mask up to the addressed lanes
  always_comb begin
    st_sel = NB'(st_be << st_off);
    st_dat = st_data << {st_off, 3'b000};
  end

  // Legal lane mask and natural alignment; the mask picks offset bits that must be zero
  always_comb begin
    legal = 1'b0;
    amask = '0;
    if (st_be == NB'(BeByte)) begin
      legal = 1'b1;
      amask = '0;
    end else if (st_be == NB'(BeHalf)) begin
      legal = 1'b1;
      amask = LB'(1);
    end else if (st_be == NB'(BeWord)) begin
      legal = 1'b1;
      amask = LB'(3);
    end else if ((NB == 8) && (st_be == NB'(BeDword))) begin
      legal = 1'b1;
      amask = LB'(7);
    end
    st_bad = ~legal | (|(st_off & amask));
  end

  // Load side: bring the addressed lanes down, keep enabled bytes, extend the rest
  always_comb begin
    shifted = ld_raw >> {ld_off, 3'b000};
    if (ld_be == NB'(BeByte)) begin
      sign_bit = shifted[7];
    end else if (ld_be == NB'(BeHalf)) begin
      sign_bit = shifted[15];
    end else if (ld_be == NB'(BeWord)) begin
      sign_bit = shifted[31];
    end else begin
      sign_bit = shifted[DATA_SIZE-1];
    end
    fill    = ld_signed & sign_bit;
    ld_data = '0;
    for (int i = 0; i < NB; i++) begin
      ld_data[8*i +: 8] = ld_be[i] ? shifted[8*i +: 8] : {8{fill}};
    end
  end

endmodule

// File: rtl/data_mem_unit.sv
// Data-memory responder: turns each core load/store into one Wishbone
// classic cycle, stalls the core while it runs and reports faults.
module data_mem_unit
  import data_mem_unit_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [DATA_SIZE-1:0]   addr,
  input  logic [DATA_SIZE-1:0]   wr_data,
  input  logic [DATA_SIZE/8-1:0] byte_en,
  input  logic                   rd_signed,
  output logic [DATA_SIZE-1:0]   rd_data,
  output logic                   mem_busy,
  output logic                   access_fault,
  data_mem_unit_if.master        bus
);

  localparam int NB = DATA_SIZE / 8;
  localparam int LB = lane_bits(DATA_SIZE);
  localparam logic [CntW-1:0]      TimeoutLast = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0]      TimeoutMax  = CntW'(TIMEOUT);
  localparam logic [DATA_SIZE-1:0] AdrMask     = ~DATA_SIZE'(NB - 1);

  mem_state_t           state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 cyc_q, cyc_d;
  logic                 we_q, we_d;
  logic [DATA_SIZE-1:0] adr_q, adr_d;
  logic [NB-1:0]        sel_q, sel_d;
  logic [DATA_SIZE-1:0] dat_o_q, dat_o_d;
  logic [DATA_SIZE-1:0] rd_data_q, rd_data_d;
  logic                 fault_q, fault_d;
  logic                 ld_signed_q, ld_signed_d;
  logic [NB-1:0]        ld_be_q, ld_be_d;
  logic [LB-1:0]        ld_off_q, ld_off_d;

  logic                 req;
  logic                 bad;
  logic                 align_bad;
  logic [NB-1:0]        st_sel;
  logic [DATA_SIZE-1:0] st_dat;
  logic [DATA_SIZE-1:0] ld_data;

  data_mem_unit_load_store_aligner #(
    .DATA_SIZE (DATA_SIZE)
  ) u_aligner (
    .st_off    (addr[LB-1:0]),
    .st_be     (byte_en),
    .st_data   (wr_data),
    .st_sel    (st_sel),
    .st_dat    (st_dat),
    .st_bad    (align_bad),
    .ld_off    (ld_off_q),
    .ld_be     (ld_be_q),
    .ld_signed (ld_signed_q),
    .ld_raw    (bus.wb_dat_i),
    .ld_data   (ld_data)
  );

  assign req = rd_en | wr_en;
  assign bad = (rd_en & wr_en) | align_bad;

  // The core is stalled for as long as a request is pending and not yet retired
  assign mem_busy     = req & (state_q != Done) & (state_q != Fault);
  assign access_fault = fault_q;
  assign rd_data      = rd_data_q;

  assign bus.wb_cyc   = cyc_q;
  assign bus.wb_stb   = cyc_q;
  assign bus.wb_we    = we_q;
  assign bus.wb_adr   = adr_q;
  assign bus.wb_sel   = sel_q;
  assign bus.wb_dat_o = dat_o_q;

  // Next-state, bus register and load-result computation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    sel_d       = sel_q;
    dat_o_d     = dat_o_q;
    rd_data_d   = rd_data_q;
    fault_d     = 1'b0;
    ld_signed_d = ld_signed_q;
    ld_be_d     = ld_be_q;
    ld_off_d    = ld_off_q;

    unique case (state_q)
      Idle: begin
        if (req) begin
          if (bad) begin
            state_d = Fault;
            fault_d = 1'b1;
          end else begin
            state_d     = Wait;
            cnt_d       = '0;
            cyc_d       = 1'b1;
            we_d        = wr_en;
            adr_d       = addr & AdrMask;
            sel_d       = st_sel;
            dat_o_d     = st_dat;
            ld_signed_d = rd_signed;
            ld_be_d     = byte_en;
            ld_off_d    = addr[LB-1:0];
          end
        end
      end

      Wait: begin
        // An ack on the last permitted cycle still completes normally
        if (bus.wb_ack) begin
          state_d = Done;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          if (!we_q) begin
            rd_data_d = ld_data;
          end
        end else begin
          cnt_d = (cnt_q == TimeoutMax) ? cnt_q : cnt_q + CntW'(1);
          if (cnt_q >= TimeoutLast) begin
            state_d = Done;
            fault_d = 1'b1;
            cyc_d   = 1'b0;
            we_d    = 1'b0;
            if (!we_q) begin
              rd_data_d = '0;
            end
          end
        end
      end

      Done: begin
        state_d = Idle;
        cnt_d   = '0;
      end

      Fault: begin
        state_d = Idle;
      end

      default: begin
        state_d = Idle;
      end
    endcase
  end

  // State, counter and output registers; reset drops any bus cycle in flight
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= Idle;
      cnt_q       <= '0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      sel_q       <= '0;
      dat_o_q     <= '0;
      rd_data_q   <= '0;
      fault_q     <= 1'b0;
      ld_signed_q <= 1'b0;
      ld_be_q     <= '0;
      ld_off_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      sel_q       <= sel_d;
      dat_o_q     <= dat_o_d;
      rd_data_q   <= rd_data_d;
      fault_q     <= fault_d;
      ld_signed_q <= ld_signed_d;
      ld_be_q     <= ld_be_d;
      ld_off_q    <= ld_off_d;
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Scoreboard bench for data_mem_unit: byte-addressed reference memory,
// Wishbone slave with programmable ack delay, decoupled monitor.
module tb_data_mem_unit;

  localparam int TMO = 4;

  typedef struct packed {
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] dat;
  } bus_t;

  typedef struct packed {
    logic        fault;
    logic [31:0] rd;
  } comp_t;

  logic        clock;
  logic        reset;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [3:0]  byte_en;
  logic        rd_signed;
  logic [31:0] rd_data;
  logic        mem_busy;
  logic        access_fault;

  data_mem_unit_if #(.DATA_SIZE(32)) bus ();

  data_mem_unit #(
    .DATA_SIZE (32),
    .TIMEOUT   (TMO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rd_en        (rd_en),
    .wr_en        (wr_en),
    .addr         (addr),
    .wr_data      (wr_data),
    .byte_en      (byte_en),
    .rd_signed    (rd_signed),
    .rd_data      (rd_data),
    .mem_busy     (mem_busy),
    .access_fault (access_fault),
    .bus          (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  bus_t        bus_q[$];
  comp_t       comp_q[$];
  logic [7:0]  rmem [0:1023];
  logic [31:0] smem [0:255];
  logic [31:0] model_rd = '0;
  int          ack_delay = 0;
  logic        ack_force = 1'b0;
  logic        mon_en = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_word(input logic [31:0] a, input logic [31:0] w);
    smem[a[9:2]] = w;
    for (int b = 0; b < 4; b++) rmem[int'(a & 32'h3FC) + b] = w[8*b +: 8];
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] a, input int size, input logic sgn);
    logic [31:0] v;
    logic [63:0] m;
    v = '0;
    for (int b = 0; b < size; b++) v = v | (32'(rmem[int'((a + b) & 32'h3FF)]) << (8 * b));
    m = (64'd1 << (8 * size)) - 64'd1;
    if (sgn && v[8*size-1]) v = v | ~m[31:0];
    return v;
  endfunction

  function automatic bus_t bus_exp(input logic [31:0] a, input logic [3:0] be,
                                   input logic wr, input logic [31:0] wd);
    bus_t e;
    logic [3:0] s;
    s     = be << a[1:0];
    e.adr = a & 32'hFFFF_FFFC;
    e.sel = s;
    e.we  = wr;
    e.dat = wd << (8 * a[1:0]);
    return e;
  endfunction

  // Issue one request, predict its outcome, hold it until retired
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a, input logic [3:0] be,
                        input logic sgn, input logic [31:0] wd, input int dly);
    int    size;
    int    exp_busy;
    int    busy_cnt;
    logic  bad;
    logic  done;
    comp_t c;
    case (be)
      4'h1:    size = 1;
      4'h3:    size = 2;
      4'hF:    size = 4;
      default: size = 0;
    endcase
    bad = (rd && wr) || (size == 0) || ((size != 0) && ((a % size) != 0));
    if (bad) begin
      c.fault  = 1'b1;
      exp_busy = 1;
    end else begin
      bus_q.push_back(bus_exp(a, be, wr, wd));
      if (dly >= TMO) begin
        c.fault  = 1'b1;
        exp_busy = TMO + 1;
        if (rd) model_rd = '0;
      end else begin
        c.fault  = 1'b0;
        exp_busy = dly + 2;
        if (rd) model_rd = ref_load(a, size, sgn);
        else for (int b = 0; b < size; b++) rmem[int'((a + b) & 32'h3FF)] = wd[8*b +: 8];
      end
    end
    c.rd = model_rd;
    comp_q.push_back(c);
    rd_en = rd; wr_en = wr; addr = a; byte_en = be; rd_signed = sgn; wr_data = wd;
    ack_delay = dly;
    busy_cnt = 0;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (mem_busy) busy_cnt++;
      else begin
        done = 1'b1;
        break;
      end
    end
    check("req_retired", {31'd0, done}, 32'd1);
    check("busy_cycles", busy_cnt, exp_busy);
    @(posedge clock); #1;
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  // Wishbone slave: acks after ack_delay wait cycles, word memory with lane writes
  initial begin : slave
    logic in_cyc;
    int   wcnt;
    in_cyc = 1'b0;
    wcnt = 0;
    bus.wb_ack = 1'b0;
    bus.wb_dat_i = '0;
    forever begin
      @(posedge clock); #1;
      if (bus.wb_cyc && bus.wb_stb) begin
        if (!in_cyc) begin
          in_cyc = 1'b1;
          wcnt = 0;
        end else wcnt++;
        if (wcnt == ack_delay) begin
          bus.wb_ack = 1'b1;
          bus.wb_dat_i = smem[bus.wb_adr[9:2]];
          if (bus.wb_we)
            for (int b = 0; b < 4; b++)
              if (bus.wb_sel[b]) smem[bus.wb_adr[9:2]][8*b +: 8] = bus.wb_dat_o[8*b +: 8];
        end else begin
          bus.wb_ack = ack_force;
          bus.wb_dat_i = $urandom;
        end
      end else begin
        in_cyc = 1'b0;
        bus.wb_ack = ack_force;
        bus.wb_dat_i = $urandom;
      end
    end
  end

  // Monitor: bus-cycle starts and request retirements against the queues
  initial begin : monitor
    logic  prev_cyc;
    bus_t  eb;
    comp_t ec;
    prev_cyc = 1'b0;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        if (bus.wb_cyc && !prev_cyc) begin
          if (bus_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_cyc: bus cycle started, none expected at %0t", $time);
          end else begin
            eb = bus_q.pop_front();
            check("wb_adr", bus.wb_adr, eb.adr);
            check("wb_sel", {28'd0, bus.wb_sel}, {28'd0, eb.sel});
            check("wb_we", {31'd0, bus.wb_we}, {31'd0, eb.we});
            check("wb_dat_o", bus.wb_dat_o, eb.dat);
          end
        end
        if ((rd_en || wr_en) && !mem_busy) begin
          if (comp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_retire: request retired, none expected at %0t", $time);
          end else begin
            ec = comp_q.pop_front();
            check("access_fault", {31'd0, access_fault}, {31'd0, ec.fault});
            check("rd_data", rd_data, ec.rd);
          end
        end else begin
          check("fault_quiet", {31'd0, access_fault}, 32'd0);
        end
      end
      prev_cyc = bus.wb_cyc;
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] a;
    logic [3:0]  be;
    logic        rd;
    logic        wr;
    int          op;
    int          r;
    int          dly;
    reset = 1'b0; rd_en = 1'b0; wr_en = 1'b0; addr = '0; wr_data = '0;
    byte_en = '0; rd_signed = 1'b0;
    for (int w = 0; w < 256; w++) set_word(32'(w * 4), $urandom);

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_fault", {31'd0, access_fault}, 32'd0);
    check("rst_cyc", {30'd0, bus.wb_cyc, bus.wb_stb}, 32'd0);
    check("rst_we", {31'd0, bus.wb_we}, 32'd0);
    check("rst_adr", bus.wb_adr, 32'd0);
    check("rst_sel", {28'd0, bus.wb_sel}, 32'd0);
    check("rst_dat_o", bus.wb_dat_o, 32'd0);
    check("rst_busy", {31'd0, mem_busy}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    mon_en = 1'b1;
    @(posedge clock); #1;

    // Directed cases
    set_word(32'h100, 32'hDEADBEEF);
    do_req(1'b1, 1'b0, 32'h100, 4'hF, 1'b1, 32'h0, 2);
    check("lw_result", rd_data, 32'hDEADBEEF);
    set_word(32'h100, 32'h80123456);
    do_req(1'b1, 1'b0, 32'h103, 4'h1, 1'b1, 32'h0, 0);
    check("lb_result", rd_data, 32'hFFFFFF80);
    do_req(1'b1, 1'b0, 32'h103, 4'h1, 1'b0, 32'h0, 1);
    check("lbu_result", rd_data, 32'h00000080);
    do_req(1'b0, 1'b1, 32'h102, 4'h3, 1'b0, 32'h00001234, 1);
    do_req(1'b1, 1'b0, 32'h102, 4'h3, 1'b0, 32'h0, 0);
    check("sh_readback", rd_data, 32'h00001234);
    do_req(1'b1, 1'b0, 32'h101, 4'hF, 1'b0, 32'h0, 0);
    check("misaligned_keeps", rd_data, 32'h00001234);
    do_req(1'b1, 1'b0, 32'h104, 4'hF, 1'b0, 32'h0, TMO + 3);
    check("timeout_rd", rd_data, 32'd0);
    do_req(1'b1, 1'b1, 32'h108, 4'hF, 1'b0, 32'h0, 0);
    do_req(1'b0, 1'b1, 32'h10C, 4'hF, 1'b0, 32'hCAFEF00D, 0);
    do_req(1'b1, 1'b0, 32'h10C, 4'hF, 1'b1, 32'h0, 3);
    check("sw_lw_b2b", rd_data, 32'hCAFEF00D);

    // Reset while the bus cycle is waiting; a late ack must have no effect
    bus_q.push_back(bus_exp(32'h110, 4'hF, 1'b0, 32'h0));
    rd_en = 1'b1; addr = 32'h110; byte_en = 4'hF; rd_signed = 1'b0; wr_data = '0;
    ack_delay = 100;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    rd_en = 1'b0;
    model_rd = '0;
    @(negedge clock);
    check("rst_wait_cyc", {31'd0, bus.wb_cyc}, 32'd0);
    check("rst_wait_rd", rd_data, 32'd0);
    check("rst_wait_busy", {31'd0, mem_busy}, 32'd0);
    @(posedge clock); #1;
    ack_force = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("late_ack_cyc", {31'd0, bus.wb_cyc}, 32'd0);
    end
    @(posedge clock); #1;
    ack_force = 1'b0;
    @(posedge clock); #1;

    // Randomized traffic
    for (int t = 0; t < 250; t++) begin
      op = $urandom_range(0, 19);
      rd = (op < 10);
      wr = (op == 0) || (op >= 10);
      r = $urandom_range(0, 9);
      if (r == 0) be = 4'($urandom_range(0, 15));
      else if (r < 4) be = 4'h1;
      else if (r < 7) be = 4'h3;
      else be = 4'hF;
      a = 32'h100 + 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (be == 4'h3) a = a & 32'hFFFF_FFFE;
        if (be == 4'hF) a = a & 32'hFFFF_FFFC;
      end
      dly = ($urandom_range(0, 9) == 0) ? TMO + 2 : $urandom_range(0, 3);
      do_req(rd, wr, a, be, 1'($urandom_range(0, 1)), $urandom, dly);
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clock); #1;
      end
    end

    repeat (5) @(negedge clock);
    check("bus_q_drained", bus_q.size(), 32'd0);
    check("comp_q_drained", comp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
